hack_spi_fetch: RTL and testbench
=================================

HACK_SPI_FETCH -- requirements
Module: hack_spi_fetch

Interface
REQ-001 Parameter READ_CMD, default 8'h03, SPI SRAM read opcode sent at the start of each transaction.
REQ-002 Parameter ADDR_BITS, default 16, SPI address field width in bits; only 16 is supported.
REQ-003 The block SHALL have the following ports:
- clk  in  1  system clock; reset is synchronous, active-high, sampled on clk.
- reset  in  1  synchronous, active-high reset.
- strobe  in  1  one-clk pulse from the Hack clock divider; requests a fetch.
- fetch_en  in  1  gates strobe; strobe is ignored when low.
- pc  in  15  Hack word address to fetch, sampled on an accepted strobe.
- spi_miso  in  1  serial data from the SRAM.
- spi_cs_n  out  1  SRAM chip select, active-low.
- spi_sck  out  1  SPI clock, mode 0, idles low.
- spi_mosi  out  1  serial data to the SRAM.
- instruction  out  16  last fetched word.
- instr_valid  out  1  one-cycle pulse when instruction updates.
- busy  out  1  transaction in progress.
- overrun  out  1  sticky flag: a strobe arrived while busy.

Function
REQ-004 States SHALL be IDLE, SETUP, SHIFT and DONE; all outputs SHALL be registered.
REQ-005 In IDLE, a strobe with fetch_en=1 SHALL latch pc, load a 40-bit shift word {READ_CMD, pc, 1'b0, 16'h0000} and enter SETUP.
REQ-006 SETUP SHALL last exactly 1 cycle with spi_cs_n=0, spi_sck=0 and spi_mosi=bit 39, then enter SHIFT.
REQ-007 SHIFT SHALL transfer 40 bits MSB first over exactly 80 cycles, 2 cycles per bit:
- Phase 0: spi_sck=0, spi_mosi=current bit.
- Phase 1: spi_sck=1, spi_mosi held.
REQ-008 spi_miso SHALL be sampled at the clk edge that ends each phase 1.
REQ-009 The last 16 sampled bits SHALL form the data word, first-received bit = instruction[15] (big-endian byte order).
REQ-010 A 6-bit bit counter SHALL count 0..39 and SHALL NOT wrap; SHIFT exits to DONE after phase 1 of bit 39.
REQ-011 DONE SHALL last 1 cycle with spi_cs_n=1, spi_sck=0, instruction updated and instr_valid=1, then return to IDLE.
REQ-012 Latency: for a strobe sampled at edge t0:
- SETUP at t1.
- SHIFT at t2..t81.
- DONE (instr_valid=1) at t82.
- IDLE at t83.
REQ-013 busy SHALL be 1 in SETUP, SHIFT and DONE, and 0 in IDLE.
REQ-014 A strobe (with fetch_en=1) in any state other than IDLE SHALL be ignored and SHALL set overrun=1; the transaction in progress SHALL be unaffected.
REQ-015 overrun SHALL clear only on reset.
REQ-016 A strobe with fetch_en=0 SHALL have no effect in any state and SHALL NOT set overrun.
REQ-017 Deasserting fetch_en mid-transaction SHALL NOT abort the transaction.
REQ-018 pc changes after the accepted strobe SHALL NOT affect the transaction in progress.
REQ-019 instruction SHALL hold its value between DONE cycles.
REQ-020 The minimum accepted strobe spacing is 83 clk cycles; closer strobes fall under REQ-014.
REQ-021 In IDLE, spi_cs_n=1, spi_sck=0 and spi_mosi=0.

Reset
REQ-022 On reset=1 at any clk edge, the next cycle SHALL show:
- state=IDLE.
- spi_cs_n=1, spi_sck=0, spi_mosi=0.
- instruction=16'h0000, instr_valid=0, busy=0, overrun=0.
- bit counter and phase cleared.
REQ-023 Reset asserted mid-SHIFT SHALL abort the transaction: no instr_valid pulse and instruction forced to 0.
REQ-024 Reset SHALL take priority over a simultaneous strobe; that strobe is dropped.

Verification
REQ-025 Basic fetch: pc=15'h1234, SRAM model returns 16'hABCD -> MOSI bits = 8'h03, 16'h2468; instruction=16'hABCD with instr_valid pulse exactly 82 cycles after strobe; cs_n low t1..t81.
REQ-026 Back-to-back: strobes at t0 and t83 -> two complete fetches, overrun=0; a strobe at t0+50 -> overrun=1 and first fetch still completes correctly.
REQ-027 Gating: strobe with fetch_en=0 -> cs_n stays 1, busy=0, overrun=0 for 100 cycles.
REQ-028 Reset mid-fetch: reset at t40 -> t41 cs_n=1, sck=0, instruction=0, busy=0, no instr_valid pulse; a new strobe at t45 fetches normally.
REQ-029 Boundary addresses: pc=15'h7FFF -> address field 16'hFFFE; pc=0 -> 16'h0000; MISO 16'h0001 and 16'h8000 -> bit-order check.
REQ-030 SCK check: exactly 40 rising edges per transaction, each high phase 1 cycle; pc changed at t5 -> transmitted address unchanged.

Source files
------------

// File: rtl/hack_spi_fetch.sv
// Fetches one 16-bit Hack instruction word from a serial SPI SRAM (mode 0).
// Each accepted strobe runs one read transaction: opcode, byte address, then 16 data bits.
module hack_spi_fetch #(
   parameter logic [7:0] READ_CMD  = 8'h03,
   parameter int         ADDR_BITS = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        strobe,
   input  logic        fetch_en,
   input  logic [14:0] pc,
   input  logic        spi_miso,
   output logic        spi_cs_n,
   output logic        spi_sck,
   output logic        spi_mosi,
   output logic [15:0] instruction,
   output logic        instr_valid,
   output logic        busy,
   output logic        overrun
);

   localparam int         SHIFT_BITS = 8 + ADDR_BITS + 16;
   localparam logic [5:0] LAST_BIT   = 6'(SHIFT_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                state_q;
   logic [5:0]            bit_cnt_q;
   logic                  phase_q;
   logic [SHIFT_BITS-1:0] shift_q;
   logic [SHIFT_BITS-1:0] shift_d;
   logic [15:0]           rx_q;
   logic [15:0]           rx_d;
   logic                  cs_n_q;
   logic                  sck_q;
   logic                  mosi_q;
   logic [15:0]           instr_q;
   logic                  valid_q;
   logic                  busy_q;
   logic                  overrun_q;
   logic                  accept;

   assign accept = strobe & fetch_en;

   // Hack addresses words; the SRAM addresses bytes, hence pc followed by a zero LSB.
   assign shift_d = {READ_CMD, pc, {(ADDR_BITS - 15){1'b0}}, 16'h0000};
   assign rx_d    = {rx_q[14:0], spi_miso};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         phase_q   <= 1'b0;
         cs_n_q    <= 1'b1;
         sck_q     <= 1'b0;
         mosi_q    <= 1'b0;
         instr_q   <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (accept && state_q != IDLE) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               valid_q <= 1'b0;
               cs_n_q  <= 1'b1;
               sck_q   <= 1'b0;
               mosi_q  <= 1'b0;
               busy_q  <= 1'b0;
               if (accept) begin
                  shift_q <= shift_d;
                  state_q <= SETUP;
                  cs_n_q  <= 1'b0;
                  mosi_q  <= shift_d[SHIFT_BITS-1];
                  busy_q  <= 1'b1;
               end
            end
            SETUP: begin
               state_q   <= SHIFT;
               bit_cnt_q <= '0;
               phase_q   <= 1'b0;
               sck_q     <= 1'b0;
               mosi_q    <= shift_q[SHIFT_BITS-1];
            end
            SHIFT: begin
               if (!phase_q) begin
                  phase_q <= 1'b1;
                  sck_q   <= 1'b1;
               end else begin
                  // MISO is captured on the edge that drops SCK, i.e. after a full high phase.
                  rx_q <= rx_d;
                  if (bit_cnt_q == LAST_BIT) begin
                     state_q <= DONE;
                     cs_n_q  <= 1'b1;
                     sck_q   <= 1'b0;
                     mosi_q  <= 1'b0;
                     instr_q <= rx_d;
                     valid_q <= 1'b1;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 6'd1;
                     phase_q   <= 1'b0;
                     sck_q     <= 1'b0;
                     shift_q   <= {shift_q[SHIFT_BITS-2:0], 1'b0};
                     mosi_q    <= shift_q[SHIFT_BITS-2];
                  end
               end
            end
            DONE: begin
               state_q   <= IDLE;
               valid_q   <= 1'b0;
               busy_q    <= 1'b0;
               bit_cnt_q <= '0;
               phase_q   <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign spi_cs_n    = cs_n_q;
   assign spi_sck     = sck_q;
   assign spi_mosi    = mosi_q;
   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_hack_spi_fetch.sv
// Bench for hack_spi_fetch: behavioural SPI SRAM responder plus a transaction-level
// expectation (command/address word, returned data, timing window) for each fetch.
module tb_hack_spi_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        strobe;
   logic        fetch_en;
   logic [14:0] pc;
   logic        spi_miso;
   logic        spi_cs_n;
   logic        spi_sck;
   logic        spi_mosi;
   logic [15:0] instruction;
   logic        instr_valid;
   logic        busy;
   logic        overrun;

   always #5 clk = ~clk;

   hack_spi_fetch #(.READ_CMD(8'h03), .ADDR_BITS(16)) dut (
      .clk         (clk),
      .reset       (reset),
      .strobe      (strobe),
      .fetch_en    (fetch_en),
      .pc          (pc),
      .spi_miso    (spi_miso),
      .spi_cs_n    (spi_cs_n),
      .spi_sck     (spi_sck),
      .spi_mosi    (spi_mosi),
      .instruction (instruction),
      .instr_valid (instr_valid),
      .busy        (busy),
      .overrun     (overrun)
   );

   int          checks   = 0;
   int          failures = 0;
   int          rise_cnt;
   int          high_run_err;
   logic [39:0] mosi_word;
   logic [15:0] sram_data;
   logic        prev_sck;
   logic        exp_ovr;
   logic [15:0] exp_instr;

   task automatic check(input string tag, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
      end
   endtask

   // Advance one clock, then act as the SRAM: record MOSI on SCK rise, drive MISO while SCK is low.
   task automatic tick();
      int idx;
      @(posedge clk);
      #1;
      if (spi_sck && !prev_sck) begin
         rise_cnt++;
         mosi_word = {mosi_word[38:0], spi_mosi};
      end
      if (spi_sck && prev_sck) high_run_err++;
      prev_sck = spi_sck;
      if (!spi_sck) begin
         idx = 39 - rise_cnt;
         if (!spi_cs_n && rise_cnt >= 24 && rise_cnt < 40) spi_miso = sram_data[idx];
         else spi_miso = 1'($urandom_range(0, 1));
      end
   endtask

   // One full fetch from cycle 0 (strobe) to cycle 83 (back in IDLE, ready for the next strobe).
   task automatic do_fetch(input string tag, input logic [14:0] p, input logic [15:0] d,
                           input int stray_k, input logic stray_fen, input logic drop_fen);
      int cs_err    = 0;
      int busy_err  = 0;
      int valid_cnt = 0;
      int valid_at  = -1;
      sram_data    = d;
      rise_cnt     = 0;
      mosi_word    = '0;
      high_run_err = 0;
      pc       = p;
      fetch_en = 1'b1;
      strobe   = 1'b1;
      tick();
      strobe   = 1'b0;
      pc       = 15'($urandom);
      fetch_en = !drop_fen;
      for (int k = 1; k <= 82; k++) begin
         if (spi_cs_n !== (k > 81)) cs_err++;
         if (busy !== 1'b1) busy_err++;
         if (instr_valid === 1'b1) begin
            valid_cnt++;
            valid_at = k;
         end
         if (k == 81) check({tag, "_hold"}, 40'(instruction), 40'(exp_instr));
         if (k == 82) check({tag, "_instr"}, 40'(instruction), 40'(d));
         if (k == 5) pc = ~p;
         if (k == stray_k) begin
            strobe   = 1'b1;
            fetch_en = stray_fen;
            if (stray_fen) exp_ovr = 1'b1;
         end
         tick();
         strobe   = 1'b0;
         fetch_en = !drop_fen;
      end
      exp_instr = d;
      check({tag, "_cs_window"}, 40'(cs_err), 40'd0);
      check({tag, "_busy"}, 40'(busy_err), 40'd0);
      check({tag, "_valid_cnt"}, 40'(valid_cnt), 40'd1);
      check({tag, "_valid_at"}, 40'(valid_at), 40'd82);
      check({tag, "_sck_rises"}, 40'(rise_cnt), 40'd40);
      check({tag, "_sck_high1"}, 40'(high_run_err), 40'd0);
      check({tag, "_mosi"}, mosi_word, {8'h03, p, 1'b0, 16'h0000});
      check({tag, "_overrun"}, 40'(overrun), 40'(exp_ovr));
      check({tag, "_idle"}, 40'({busy, spi_cs_n, spi_sck, spi_mosi, instr_valid}), 40'(5'b01000));
      check({tag, "_keep"}, 40'(instruction), 40'(d));
      fetch_en = 1'b1;
   endtask

   initial begin
      int err;
      reset     = 1'b1;
      strobe    = 1'b0;
      fetch_en  = 1'b0;
      pc        = '0;
      spi_miso  = 1'b0;
      prev_sck  = 1'b0;
      rise_cnt  = 0;
      mosi_word = '0;
      sram_data = '0;
      exp_ovr   = 1'b0;
      exp_instr = '0;
      high_run_err = 0;
      tick();
      tick();
      check("rst_outputs", 40'({spi_cs_n, spi_sck, spi_mosi, instr_valid, busy, overrun}), 40'(6'b100000));
      check("rst_instr", 40'(instruction), 40'h0);
      reset = 1'b0;
      tick();

      do_fetch("basic", 15'h1234, 16'hABCD, -1, 1'b0, 1'b0);
      do_fetch("b2b_a", 15'($urandom), 16'($urandom), -1, 1'b0, 1'b0);
      do_fetch("b2b_b", 15'($urandom), 16'($urandom), -1, 1'b0, 1'b0);
      do_fetch("pc_max", 15'h7FFF, 16'h0001, -1, 1'b0, 1'b0);
      do_fetch("pc_zero", 15'h0000, 16'h8000, -1, 1'b0, 1'b0);
      do_fetch("fen_drop", 15'($urandom), 16'($urandom), 30, 1'b0, 1'b1);

      // Gated strobe must be invisible.
      fetch_en = 1'b0;
      strobe   = 1'b1;
      tick();
      strobe = 1'b0;
      err = 0;
      for (int k = 0; k < 100; k++) begin
         if (spi_cs_n !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0 || instr_valid !== 1'b0) err++;
         tick();
      end
      check("gating", 40'(err), 40'd0);
      fetch_en = 1'b1;

      for (int r = 0; r < 4; r++) begin
         do_fetch("random", 15'($urandom), 16'($urandom), -1, 1'b0, 1'b0);
      end
      do_fetch("overrun", 15'($urandom), 16'($urandom), 50, 1'b1, 1'b0);
      do_fetch("ovr_sticky", 15'($urandom), 16'($urandom), -1, 1'b0, 1'b0);

      // Reset in the middle of SHIFT aborts the fetch.
      sram_data = 16'($urandom);
      pc        = 15'($urandom);
      strobe    = 1'b1;
      tick();
      strobe = 1'b0;
      err = 0;
      for (int k = 1; k < 40; k++) begin
         if (instr_valid === 1'b1) err++;
         tick();
      end
      reset = 1'b1;
      tick();
      reset     = 1'b0;
      exp_ovr   = 1'b0;
      exp_instr = '0;
      check("midrst_pins", 40'({spi_cs_n, spi_sck, spi_mosi, busy, instr_valid, overrun}), 40'(6'b100000));
      check("midrst_instr", 40'(instruction), 40'h0);
      for (int k = 41; k < 45; k++) begin
         tick();
         if (instr_valid === 1'b1 || busy !== 1'b0) err++;
      end
      check("midrst_quiet", 40'(err), 40'd0);
      do_fetch("after_rst", 15'($urandom), 16'($urandom), -1, 1'b0, 1'b0);

      // A strobe coinciding with reset is dropped.
      reset  = 1'b1;
      strobe = 1'b1;
      tick();
      reset  = 1'b0;
      strobe = 1'b0;
      tick();
      check("rst_strobe_drop", 40'({busy, spi_cs_n, instruction}), {22'd0, 1'b0, 1'b1, 16'h0000});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
